// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types and constants for the APB master arbiter.
//   apb_state_t        : bus-sequencing FSM states (IDLE, SETUP, ACCESS)
//   APB_DW             : APB data / address width
//   CONTROL_REG_ADDR   : traffic-light controller control register
//   CURRENT_STATE_ADDR : traffic-light controller current-state register
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_DW = 32;

  localparam logic [APB_DW-1:0] CONTROL_REG_ADDR   = 32'h0000_0000;
  localparam logic [APB_DW-1:0] CURRENT_STATE_ADDR = 32'h0000_0004;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational one-hot round-robin grant plus the last-grant pointer.
// The search starts one position after the last winner and wraps, so every
// active requester is reached within N grants.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : request bits
//   i_update       : a grant was accepted this cycle; move the pointer to it
//   o_grant        : one-hot winner (all zero when i_req is zero)
//   o_grant_idx    : binary index of the winner
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_update,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);

  logic [IW-1:0] r_last;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;
  logic          w_found;
  int            w_cand;

  // Walk offsets 1..N from the pointer; the first set request wins.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int off = 1; off <= N; off++) begin
      w_cand = (int'(r_last) + off) % N;
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        w_idx            = IW'(w_cand);
        w_grant[w_cand]  = 1'b1;
      end
    end
  end

  // Reset to N-1 so requester 0 is searched first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_last <= IW'(N - 1);
    end else if (i_update) begin
      r_last <= w_idx;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;

endmodule

// File: rtl/apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb_master_arbiter
// Round-robin APB3 master shared by NREQ local requesters. One request is
// accepted at a time, run through SETUP/ACCESS, and answered on the granted
// requester's rsp_valid bit only. A wait counter bounds ACCESS when the slave
// never raises PREADY (TIMEOUT=0 disables it).
//
// Request handshake: requester i presents req_valid[i] with its write/addr/
// wdata stable; req_ready is a combinational one-hot grant visible only in
// IDLE. The request is captured on a rising edge where req_valid[i] &&
// req_ready[i]. req_valid may drop before that edge at no cost; after it,
// the requester's inputs are no longer looked at.
//
// Ports:
//   PCLK, PRESETn          : clock, asynchronous active-low reset
//   req_valid/req_write    : per-requester request and direction
//   req_addr/req_wdata     : per-requester 32-bit fields, requester i at [32i+:32]
//   req_ready              : one-hot accept (combinational)
//   rsp_valid              : one-hot, one-cycle completion pulse
//   rsp_rdata, rsp_err     : read data / timeout flag, valid with rsp_valid
//   PSEL..PWDATA           : registered APB master outputs
//   PRDATA, PREADY         : APB slave response
//   o_dbg_state            : current FSM state
// -----------------------------------------------------------------------------
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [APB_DW-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic                 PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [APB_DW-1:0]    PADDR,
  output logic [APB_DW-1:0]    PWDATA,
  input  logic [APB_DW-1:0]    PRDATA,
  input  logic                 PREADY,
  output apb_state_t           o_dbg_state
);

  localparam int IW = $clog2(NREQ);
  // Counter value on the last permitted ACCESS cycle without PREADY.
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

  apb_state_t r_state, w_state_nxt;

  logic [NREQ-1:0]   w_grant;
  logic [IW-1:0]     w_grant_idx;
  logic              w_handshake;
  logic              w_done;
  logic              w_err;
  logic              w_timeout;
  int                w_base;
  logic              w_sel_write;
  logic [APB_DW-1:0] w_sel_addr;
  logic [APB_DW-1:0] w_sel_wdata;
  logic [NREQ-1:0]   w_rsp_onehot;

  logic [IW-1:0]     r_idx;
  logic              r_write;
  logic [APB_DW-1:0] r_addr;
  logic [APB_DW-1:0] r_wdata;
  logic              r_psel;
  logic              r_penable;
  logic [4:0]        r_wait;
  logic [NREQ-1:0]   r_rsp_valid;
  logic [APB_DW-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IW)
  ) u_rr_arbiter (
    .i_clk       (PCLK),
    .i_rst_n     (PRESETn),
    .i_req       (req_valid),
    .i_update    (w_handshake),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // The grant is only offered in IDLE; gating with PRESETn keeps it at zero
  // while reset is asserted even though the state is already IDLE.
  assign req_ready   = (r_state == IDLE && PRESETn) ? w_grant : '0;
  assign w_handshake = |(req_valid & req_ready);

  always_comb begin
    w_base      = int'(w_grant_idx) * APB_DW;
    w_sel_write = req_write[w_grant_idx];
    w_sel_addr  = req_addr[w_base +: APB_DW];
    w_sel_wdata = req_wdata[w_base +: APB_DW];
  end

  assign w_timeout    = (TIMEOUT != 0) && (r_wait == TO_LAST);
  assign w_rsp_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_idx;

  // FSM state register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and completion decode. PREADY wins over a timeout that would
  // fire on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_handshake) w_state_nxt = SETUP;
      end
      SETUP: begin
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
          w_err       = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Capture, APB drive, wait counter and response registers. The captured
  // address/data registers drive PADDR/PWDATA directly, so they are stable
  // from SETUP through ACCESS.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_idx       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_wait      <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= '0;

      if (w_handshake) begin
        r_idx   <= w_grant_idx;
        r_write <= w_sel_write;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_write ? w_sel_wdata : '0;
        r_psel  <= 1'b1;
      end

      if (r_state == SETUP) r_penable <= 1'b1;

      if (w_done) begin
        r_psel      <= 1'b0;
        r_penable   <= 1'b0;
        r_rsp_valid <= w_rsp_onehot;
        r_rsp_err   <= w_err;
        r_rsp_rdata <= (w_err || r_write) ? '0 : PRDATA;
      end

      if (r_state == ACCESS && !PREADY && !w_timeout) begin
        r_wait <= r_wait + 5'd1;
      end else begin
        r_wait <= '0;
      end
    end
  end

  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_write;
  assign PADDR       = r_addr;
  assign PWDATA      = r_wdata;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arbiter
// Directed bench: a traffic-light APB slave (control at 0x0, current state at
// 0x4, PREADY one cycle late or zero-wait), request driver tasks, and a
// response scoreboard fed by an expected queue.
// -----------------------------------------------------------------------------
module tb_apb_master_arbiter;
  import apb_pkg::*;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic PCLK;
  logic PRESETn;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // ---------------- DUT ----------------
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*32-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_rdata;
  logic               rsp_err;
  logic               PSEL, PENABLE, PWRITE;
  logic [31:0]        PADDR, PWDATA, PRDATA;
  logic               PREADY;
  apb_state_t         dbg_state;

  apb_master_arbiter #(
    .NREQ    (NREQ),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .req_valid   (req_valid),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .o_dbg_state (dbg_state)
  );

  // ---------------- traffic-light slave ----------------
  // Current state encodes {NS[1:0], EW[1:0]}: GREEN=2, YELLOW=1, RED=0.
  // Writing control with bit0 set advances 8 -> 4 -> 2 -> 1 -> 8.
  logic [31:0] s_ctrl;
  logic [31:0] s_state;
  int          s_wcnt;
  bit          zero_wait;
  logic        s_addr_ok;

  function automatic logic [31:0] tl_next(input logic [31:0] st);
    case (st)
      32'h8:   return 32'h4;
      32'h4:   return 32'h2;
      32'h2:   return 32'h1;
      default: return 32'h8;
    endcase
  endfunction

  assign s_addr_ok = (PADDR == CONTROL_REG_ADDR) || (PADDR == CURRENT_STATE_ADDR);
  assign PREADY    = PSEL && PENABLE && s_addr_ok && (zero_wait || s_wcnt >= 1);
  assign PRDATA    = (PADDR == CURRENT_STATE_ADDR) ? s_state :
                     (PADDR == CONTROL_REG_ADDR)   ? s_ctrl  : 32'hDEAD_BEEF;

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      s_wcnt  <= 0;
      s_ctrl  <= 32'h0;
      s_state <= 32'h8;
    end else begin
      if (PSEL && PENABLE && !PREADY) s_wcnt <= s_wcnt + 1;
      else                            s_wcnt <= 0;
      if (PSEL && PENABLE && PREADY && PWRITE && PADDR == CONTROL_REG_ADDR) begin
        s_ctrl <= PWDATA;
        if (PWDATA[0]) s_state <= tl_next(s_state);
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected response: {rsp_err, rsp_valid, rsp_rdata}.
  logic [34:0] exp_q[$];

  always @(negedge PCLK) begin
    if (PRESETn && |rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'h0);
      end else begin
        check("rsp", 64'({rsp_err, rsp_valid, rsp_rdata}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver ----------------
  // One request from requester idx, checking the grant, the SETUP phase,
  // the number of ACCESS cycles and that PSEL/PENABLE are low with the
  // response pulse. The response payload is checked by the scoreboard.
  task automatic do_txn(input int idx, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input bit exp_err, input int exp_access);
    logic [NREQ-1:0] oh;
    int acc;
    int budget;
    oh = '0;
    oh[idx] = 1'b1;
    exp_q.push_back({exp_err, oh, exp_rdata});
    @(negedge PCLK);
    req_valid                 = oh;
    req_write[idx]            = wr;
    req_addr[idx*32 +: 32]    = addr;
    req_wdata[idx*32 +: 32]   = wdata;
    #1;
    check("req_ready", 64'(req_ready), 64'(oh));
    @(negedge PCLK);
    // Captured already; these changes must not reach the bus.
    req_valid               = '0;
    req_addr[idx*32 +: 32]  = 32'hFFFF_FFF0;
    req_wdata[idx*32 +: 32] = 32'h1234_5678;
    req_write[idx]          = ~wr;
    check("setup_psel",    64'(PSEL), 64'h1);
    check("setup_penable", 64'(PENABLE), 64'h0);
    check("setup_paddr",   64'(PADDR), 64'(addr));
    check("setup_pwrite",  64'(PWRITE), 64'(wr));
    check("setup_pwdata",  64'(PWDATA), wr ? 64'(wdata) : 64'h0);
    check("setup_state",   64'(dbg_state), 64'(SETUP));
    acc = 0;
    budget = 0;
    while (rsp_valid == '0 && budget < 60) begin
      @(negedge PCLK);
      budget++;
      if (PSEL && PENABLE) begin
        acc++;
        if (PADDR !== addr) check("access_paddr_hold", 64'(PADDR), 64'(addr));
      end
    end
    check("rsp_seen",      64'(|rsp_valid), 64'h1);
    check("access_cycles", 64'(acc), 64'(exp_access));
    check("bus_idle_rsp",  64'({PSEL, PENABLE}), 64'h0);
  endtask

  // ---------------- stimulus ----------------
  logic [NREQ-1:0] fair_grant[4];
  int              fair_cyc[4];
  int              n_fair;
  int              cyc;

  initial begin
    PRESETn   = 1'b0;
    req_valid = 2'b11;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    zero_wait = 1'b0;

    // Reset values, with requests pending to show req_ready is held off.
    #12;
    check("rst_psel",      64'(PSEL), 64'h0);
    check("rst_penable",   64'(PENABLE), 64'h0);
    check("rst_pwrite",    64'(PWRITE), 64'h0);
    check("rst_paddr",     64'(PADDR), 64'h0);
    check("rst_pwdata",    64'(PWDATA), 64'h0);
    check("rst_req_ready", 64'(req_ready), 64'h0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'h0);
    check("rst_rsp_err",   64'(rsp_err), 64'h0);
    check("rst_state",     64'(dbg_state), 64'(IDLE));
    req_valid = '0;
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Read after reset: GREEN/RED = 8; read carries garbage wdata that must not appear.
    do_txn(1, 1'b0, CURRENT_STATE_ADDR, 32'hBAD0_0001, 32'h0000_0008, 1'b0, 2);
    // Write control=1: slave advances to YELLOW/RED; write returns rdata 0.
    do_txn(0, 1'b1, CONTROL_REG_ADDR, 32'h0000_0001, 32'h0, 1'b0, 2);
    check("slave_ctrl", 64'(s_ctrl), 64'h1);
    do_txn(1, 1'b0, CURRENT_STATE_ADDR, 32'hBAD0_0002, 32'h0000_0004, 1'b0, 2);

    // Fairness with a zero-wait slave: req0 reads state, req1 writes control=2
    // (no advance). PRDATA during req1's writes is nonzero; rsp_rdata must be 0.
    zero_wait = 1'b1;
    exp_q.push_back({1'b0, 2'b01, 32'h4});
    exp_q.push_back({1'b0, 2'b10, 32'h0});
    exp_q.push_back({1'b0, 2'b01, 32'h4});
    exp_q.push_back({1'b0, 2'b10, 32'h0});
    @(negedge PCLK);
    req_write = 2'b10;
    req_addr  = {CONTROL_REG_ADDR, CURRENT_STATE_ADDR};
    req_wdata = {32'h0000_0002, 32'h0};
    req_valid = 2'b11;
    n_fair = 0;
    cyc = 0;
    while (n_fair < 4 && cyc < 40) begin
      #1;
      if (|req_ready) begin
        fair_grant[n_fair] = req_ready;
        fair_cyc[n_fair]   = cyc;
        n_fair++;
      end
      @(negedge PCLK);
      cyc++;
    end
    req_valid = '0;
    check("fair_count", 64'(n_fair), 64'h4);
    check("fair_g0", 64'(fair_grant[0]), 64'h1);
    check("fair_g1", 64'(fair_grant[1]), 64'h2);
    check("fair_g2", 64'(fair_grant[2]), 64'h1);
    check("fair_g3", 64'(fair_grant[3]), 64'h2);
    for (int i = 1; i < 4; i++) begin
      check("fair_gap", 64'(fair_cyc[i] - fair_cyc[i-1]), 64'h3);
    end
    repeat (8) @(negedge PCLK);
    check("fair_drain", 64'(exp_q.size()), 64'h0);
    zero_wait = 1'b0;

    // Timeout: unmapped address never answers; PRDATA there is 0xDEADBEEF.
    do_txn(0, 1'b1, 32'h0000_0008, 32'h0000_0055, 32'h0, 1'b1, TIMEOUT);

    // Reset mid-transfer. The pointer last pointed at req0, so without the
    // reset req1 would be next.
    @(negedge PCLK);
    req_write = 2'b01;
    req_addr  = {32'h0, 32'h0000_0008};
    req_wdata = {32'h0, 32'h0000_0077};
    req_valid = 2'b01;
    @(negedge PCLK);
    req_valid = '0;
    repeat (3) @(negedge PCLK);
    check("midrst_in_access", 64'({PSEL, PENABLE}), 64'h3);
    PRESETn   = 1'b0;
    req_valid = 2'b11;
    #1;
    check("midrst_psel",      64'(PSEL), 64'h0);
    check("midrst_penable",   64'(PENABLE), 64'h0);
    check("midrst_paddr",     64'(PADDR), 64'h0);
    check("midrst_pwrite",    64'(PWRITE), 64'h0);
    check("midrst_pwdata",    64'(PWDATA), 64'h0);
    check("midrst_req_ready", 64'(req_ready), 64'h0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    check("midrst_first_grant", 64'(req_ready), 64'h1);
    req_valid = '0;
    repeat (24) @(negedge PCLK);
    check("final_drain", 64'(exp_q.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Round-robin APB master that lets NREQ local requesters share one APB3 bus segment: the pedestrian-button logic, the supervisory CPU bridge and similar agents, all driving the traffic-light controller's control and current-state registers. Each requester posts a single read or write. The block grants one requester at a time, runs the APB setup/access sequence, waits for PREADY (bounded by a timeout), and returns the response to the granted requester only.

## Interface
Parameters:
- NREQ, 2: number of requesters, 2..8
- TIMEOUT, 16: maximum ACCESS cycles waiting for PREADY; 0 disables the timeout

Ports (one clock; reset is asynchronous and active-low):
- PCLK  in  1  clock; all logic on rising edge
- PRESETn  in  1  asynchronous active-low reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_write  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*32  per-requester address; requester i uses bits [32i+31:32i]
- req_wdata  in  NREQ*32  per-requester write data, same packing
- req_ready  out  NREQ  one-hot accept; request i is captured on an edge where req_valid[i] && req_ready[i]
- rsp_valid  out  NREQ  one-hot, one-cycle completion pulse
- rsp_rdata  out  32  read data, valid while any rsp_valid bit is high
- rsp_err  out  1  timeout flag, valid while any rsp_valid bit is high
- PSEL, PENABLE, PWRITE  out  1 each  APB master controls
- PADDR, PWDATA  out  32 each  APB address and write data
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready

## Operation
- FSM (apb_state_t): IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready is combinational. It is the one-hot round-robin winner among the set req_valid bits; all zero when no request is pending.
  - On a handshake, the block latches the winner index, write, address and data, updates the last-grant pointer to the winner, and moves to SETUP.
- SETUP:
  - Drives PSEL=1, PENABLE=0, PADDR, PWRITE, and PWDATA. PWDATA is 0 for reads.
  - Always lasts exactly one cycle, then moves to ACCESS.
- ACCESS:
  - Drives PSEL=1, PENABLE=1 and holds PADDR, PWRITE and PWDATA stable.
  - On an edge with PREADY=1: register PRDATA into rsp_rdata (reads; writes return 0), set rsp_err=0, pulse rsp_valid[winner], and return to IDLE.
- Timeout:
  - A 5-bit wait counter counts ACCESS cycles without PREADY.
  - When the counter reaches TIMEOUT (TIMEOUT≠0), the transfer ends: rsp_valid[winner] pulses, rsp_err=1, rsp_rdata=0, and the FSM returns to IDLE.
  - This covers a slave that never answers, e.g. a write to a read-only address.
- Round-robin:
  - Priority search starts at last_grant+1 mod NREQ.
  - The reset value of last_grant is NREQ-1, so requester 0 has priority first.
  - A requester that holds req_valid high is served at most once per NREQ grants while others are requesting.
- req_valid may drop before its grant without side effects. Once a request is captured, later changes to that requester's inputs are ignored.
- Reset (asynchronous, including mid-transfer): all outputs go to 0 immediately, the FSM goes to IDLE, and last_grant goes to NREQ-1. An in-flight transfer is dropped and produces no response.

## Timing
- Reset values: PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- APB outputs and rsp_* are registered. req_ready is the only combinational output.
- Zero-wait slave sequence:
  - E0: handshake edge.
  - E0→E1: SETUP.
  - E1→E2: ACCESS, with PREADY sampled at E2.
  - E2→E3: rsp_valid high; the FSM is already IDLE, so the next handshake can occur at E3.
  - Peak throughput is one transfer per 3 cycles.
- Each wait state adds one ACCESS cycle. A timed-out transfer occupies 1 + TIMEOUT bus cycles.
- PSEL and PENABLE fall on the same edge that registers rsp_valid, so there are no back-to-back ACCESS phases.

## Structure
- Package apb_pkg holds:
  - typedef enum apb_state_t {IDLE, SETUP, ACCESS}
  - localparams for the traffic-light register map: CONTROL_REG_ADDR=32'h0, CURRENT_STATE_ADDR=32'h4
  - localparam APB_DW=32
- Sub-module rr_arbiter (parameter N) contains the combinational one-hot grant from request bits and the last-grant pointer. The FSM, request capture, APB drive and timeout counter stay in the top module.

## Test plan
Scenarios 1, 2 and 4 run against the traffic-light slave, where CONTROL_REG_ADDR=0, CURRENT_STATE_ADDR=4, and PREADY is one-cycle-late.
- Write: req 0 writes addr 0x0, data 0x1 → PSEL/PENABLE sequence correct; rsp_valid=2'b01 for one cycle; rsp_err=0; the slave advances one state.
- Read after reset: req 1 reads addr 0x4 → rsp_valid=2'b10; rsp_rdata=0x0000_0008 (GREEN/RED); rsp_err=0.
- Fairness: req_valid=2'b11 held for 4 transfers with a zero-wait slave → grant order 0,1,0,1; one handshake every 3 cycles.
- Timeout: TIMEOUT=16, req 0 writes addr 0x8 (no PREADY) → exactly 16 ACCESS cycles, then rsp_valid=2'b01, rsp_err=1, rsp_rdata=0.
- Reset mid-transfer: PRESETn low during ACCESS → PSEL, PENABLE and all outputs 0 before the next edge; no rsp_valid; the first grant after release goes to req 0.
